// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port used by the MEM stage.
// The master drives the request fields; the slave returns read data and ack.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack port,
// stalls upstream while an access is outstanding and registers MEM/WB fields.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic [1:0]        wbselect_in,
  input  logic              regwrite_in,
  input  logic [4:0]        dst_in,
  mem_access_stage_if.master dmem,
  output logic              stall,
  output logic [31:0]       inst_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   mem_data_out,
  output logic [1:0]        wbselect_out,
  output logic              regwrite_out,
  output logic [4:0]        dst_out,
  output logic              misalign_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;

  logic [2:0]      funct3;
  logic            memop;
  logic            is_store;
  logic            illegal;
  logic            in_access;
  logic [XLEN-1:0] store_data;
  logic [3:0]      store_strb;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  logic [31:0]     inst_next;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] alu_next;
  logic [XLEN-1:0] data_next;
  logic [1:0]      wbselect_next;
  logic            regwrite_next;
  logic [4:0]      dst_next;
  logic            misalign_next;

  assign funct3    = inst_in[14:12];
  assign memop     = memread_in | memwrite_in;
  // A request with both read and write set is treated as a load.
  assign is_store  = memwrite_in & ~memread_in;
  assign in_access = (state == ACCESS);

  assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
                || ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00))
                || ((funct3[1:0] == 2'b01) && alu_in[0]);

  always_comb begin
    store_data = rs2_in;
    store_strb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{rs2_in[7:0]}};
        store_strb = 4'b0001 << alu_in[1:0];
      end
      2'b01: begin
        store_data = {2{rs2_in[15:0]}};
        store_strb = 4'b0011 << alu_in[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = dmem.rdata[7:0];
    case (alu_in[1:0])
      2'b01:   byte_sel = dmem.rdata[15:8];
      2'b10:   byte_sel = dmem.rdata[23:16];
      2'b11:   byte_sel = dmem.rdata[31:24];
      default: byte_sel = dmem.rdata[7:0];
    endcase
    half_sel = alu_in[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = dmem.rdata;
    endcase
  end

  assign dmem.req   = in_access;
  assign dmem.we    = in_access & is_store;
  assign dmem.addr  = {alu_in[XLEN-1:2], 2'b00};
  assign dmem.wdata = store_data;
  assign dmem.wstrb = (in_access && is_store) ? store_strb : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Defaults describe a bubble into MEM/WB; only real completions override them.
  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    inst_next     = '0;
    pc_next       = '0;
    alu_next      = '0;
    data_next     = '0;
    wbselect_next = '0;
    regwrite_next = 1'b0;
    dst_next      = '0;
    misalign_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop && !illegal) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end else begin
          inst_next     = inst_in;
          pc_next       = pc_in;
          alu_next      = alu_in;
          wbselect_next = wbselect_in;
          dst_next      = dst_in;
          misalign_next = memop;
          regwrite_next = regwrite_in & ~memop;
        end
      end
      ACCESS: begin
        stall = ~dmem.ack;
        if (dmem.ack) begin
          state_next    = IDLE;
          inst_next     = inst_in;
          pc_next       = pc_in;
          alu_next      = alu_in;
          wbselect_next = wbselect_in;
          dst_next      = dst_in;
          regwrite_next = regwrite_in;
          data_next     = is_store ? '0 : load_data;
        end
      end
      default: state_next = IDLE;
    endcase
    // Upstream must never be frozen while the stage itself is held in reset.
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out     <= '0;
      pc_out       <= '0;
      alu_out      <= '0;
      mem_data_out <= '0;
      wbselect_out <= '0;
      regwrite_out <= 1'b0;
      dst_out      <= '0;
      misalign_out <= 1'b0;
    end else begin
      inst_out     <= inst_next;
      pc_out       <= pc_next;
      alu_out      <= alu_next;
      mem_data_out <= data_next;
      wbselect_out <= wbselect_next;
      regwrite_out <= regwrite_next;
      dst_out      <= dst_next;
      misalign_out <= misalign_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a queue of expected MEM/WB results.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_in, pc_in, alu_in, rs2_in;
  logic        memread_in, memwrite_in, regwrite_in;
  logic [1:0]  wbselect_in;
  logic [4:0]  dst_in;
  logic        stall;
  logic [31:0] inst_out, pc_out, alu_out, mem_data_out;
  logic [1:0]  wbselect_out;
  logic        regwrite_out, misalign_out;
  logic [4:0]  dst_out;

  mem_access_stage_if dmem ();

  mem_access_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_in      (inst_in),
    .pc_in        (pc_in),
    .alu_in       (alu_in),
    .rs2_in       (rs2_in),
    .memread_in   (memread_in),
    .memwrite_in  (memwrite_in),
    .wbselect_in  (wbselect_in),
    .regwrite_in  (regwrite_in),
    .dst_in       (dst_in),
    .dmem         (dmem),
    .stall        (stall),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .alu_out      (alu_out),
    .mem_data_out (mem_data_out),
    .wbselect_out (wbselect_out),
    .regwrite_out (regwrite_out),
    .dst_out      (dst_out),
    .misalign_out (misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    int          ack_delay;
    logic [31:0] exp_data;
    logic        exp_mis;
    int          exp_stall;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } op_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data;
    logic [1:0]  wbsel;
    logic        rw;
    logic [4:0]  dst;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mkOp(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                               input logic rd, input logic wr, input logic [31:0] rdata,
                               input int ack_delay, input logic [31:0] exp_data, input logic exp_mis,
                               input int exp_stall, input logic [3:0] exp_wstrb,
                               input logic [31:0] exp_wdata);
    op_t o;
    o.f3 = f3; o.alu = alu; o.rs2 = rs2; o.rd = rd; o.wr = wr; o.rdata = rdata;
    o.ack_delay = ack_delay; o.exp_data = exp_data; o.exp_mis = exp_mis;
    o.exp_stall = exp_stall; o.exp_we = wr & ~rd; o.exp_wstrb = exp_wstrb;
    o.exp_wdata = exp_wdata;
    return o;
  endfunction

  // Drives one EX/MEM entry (called at a falling edge) and services the memory port
  // until the stage releases stall and the entry is captured.
  task automatic applyStimulus(input op_t op);
    exp_t e;
    int   stall_cnt = 0;
    int   req_idx = 0;
    bit   done = 0;
    inst_in     = {17'd0, op.f3, pc_ctr[6:2], 7'h03};
    pc_in       = pc_ctr;
    alu_in      = op.alu;
    rs2_in      = op.rs2;
    memread_in  = op.rd;
    memwrite_in = op.wr;
    regwrite_in = ~(op.wr & ~op.rd);
    wbselect_in = op.rd ? 2'b01 : 2'b00;
    dst_in      = pc_ctr[6:2];
    e.inst  = inst_in;
    e.pc    = pc_in;
    e.alu   = op.alu;
    e.data  = op.exp_data;
    e.wbsel = wbselect_in;
    e.rw    = regwrite_in & ~op.exp_mis;
    e.dst   = dst_in;
    e.mis   = op.exp_mis;
    sb.push_back(e);
    pc_ctr = pc_ctr + 32'd4;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      dmem.ack = 1'b0;
      if (dmem.req === 1'b1) begin
        if (req_idx == 0) begin
          checkValue("dmem_addr", dmem.addr, {op.alu[31:2], 2'b00});
          checkValue("dmem_we", 32'(dmem.we), 32'(op.exp_we));
          checkValue("dmem_wstrb", 32'(dmem.wstrb), 32'(op.exp_wstrb));
          if (op.exp_we) checkValue("dmem_wdata", dmem.wdata, op.exp_wdata);
        end
        if (req_idx == op.ack_delay) begin
          dmem.ack   = 1'b1;
          dmem.rdata = op.rdata;
        end
        req_idx++;
      end
      #1;
      if (stall === 1'b1) stall_cnt++;
      else done = 1;
      @(posedge clk);
      #1;
      dmem.ack = 1'b0;
      if (!done) @(negedge clk);
    end
    checkValue("completion_in_budget", 32'(done), 32'd1);
    checkValue("stall_cycles", stall_cnt, op.exp_stall);
    checkValue("req_seen", 32'(req_idx > 0), 32'(op.exp_stall > 0));
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkValue("inst_out", inst_out, e.inst);
      checkValue("pc_out", pc_out, e.pc);
      checkValue("alu_out", alu_out, e.alu);
      checkValue("mem_data_out", mem_data_out, e.data);
      checkValue("wbselect_out", 32'(wbselect_out), 32'(e.wbsel));
      checkValue("regwrite_out", 32'(regwrite_out), 32'(e.rw));
      checkValue("dst_out", 32'(dst_out), 32'(e.dst));
      checkValue("misalign_out", 32'(misalign_out), 32'(e.mis));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_req"}, 32'(dmem.req), 32'd0);
    checkValue({tag, "_we"}, 32'(dmem.we), 32'd0);
    checkValue({tag, "_stall"}, 32'(stall), 32'd0);
    checkValue({tag, "_alu_out"}, alu_out, 32'd0);
    checkValue({tag, "_inst_out"}, inst_out, 32'd0);
    checkValue({tag, "_mem_data_out"}, mem_data_out, 32'd0);
    checkValue({tag, "_regwrite_out"}, 32'(regwrite_out), 32'd0);
    checkValue({tag, "_misalign_out"}, 32'(misalign_out), 32'd0);
  endtask

  task automatic clearInputs();
    inst_in = '0; pc_in = '0; alu_in = '0; rs2_in = '0;
    memread_in = 0; memwrite_in = 0; regwrite_in = 0; wbselect_in = '0; dst_in = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clearInputs();
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Loads: LW with two wait cycles, then byte/half variants with sign handling.
    @(negedge clk);
    applyStimulus(mkOp(3'b010, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 0, 3, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b000, 32'h203, 32'h0, 1, 0, 32'h80123456, 1, 32'hFFFFFF80, 0, 2, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b100, 32'h203, 32'h0, 1, 0, 32'h80123456, 0, 32'h00000080, 0, 1, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b001, 32'h202, 32'h0, 1, 0, 32'h80123456, 0, 32'hFFFF8012, 0, 1, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b101, 32'h200, 32'h0, 1, 0, 32'h80129456, 0, 32'h00009456, 0, 1, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();

    // Stores with byte, half and word formatting.
    applyStimulus(mkOp(3'b000, 32'h301, 32'h000000A5, 0, 1, 32'h0, 0, 32'h0, 0, 1, 4'b0010, 32'hA5A5A5A5));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b001, 32'h302, 32'h00001234, 0, 1, 32'h0, 1, 32'h0, 0, 2, 4'b1100, 32'h12341234));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b010, 32'h304, 32'hCAFEF00D, 0, 1, 32'h0, 0, 32'h0, 0, 1, 4'b1111, 32'hCAFEF00D));
    @(negedge clk); checkOutput();

    // Illegal accesses: no request, no stall, fault flagged.
    applyStimulus(mkOp(3'b010, 32'h102, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b001, 32'h201, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b011, 32'h100, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();

    // Back-to-back non-memory ops pass through with single-cycle latency.
    applyStimulus(mkOp(3'b000, 32'h55, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();
    applyStimulus(mkOp(3'b000, 32'h56, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();

    // Read and write both set behaves as a load.
    applyStimulus(mkOp(3'b010, 32'h400, 32'hFFFFFFFF, 1, 1, 32'h11223344, 0, 32'h11223344, 0, 1, 4'b0000, 32'h0));
    @(negedge clk); checkOutput();

    // Reset while an access is outstanding, then a stray ack afterwards.
    inst_in = {17'd0, 3'b010, 5'd9, 7'h03}; pc_in = 32'h2000; alu_in = 32'h500;
    memread_in = 1; memwrite_in = 0; regwrite_in = 1; wbselect_in = 2'b01; dst_in = 5'd9;
    @(posedge clk); #1;
    checkValue("access_req_before_reset", 32'(dmem.req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAllZero("reset_in_access");
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
    dmem.ack = 1'b1;
    dmem.rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    checkAllZero("late_ack");
    @(posedge clk); #1;
    checkAllZero("idle_after_late_ack");

    checkValue("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes registered EX/MEM fields and performs the data-memory access for loads and stores.
- Drives a req/ack data-memory port with byte/half/word formatting.
- Stalls upstream stages while a memory access is outstanding.
- Registers results into the MEM/WB fields consumed by writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_in  in  32  instruction from EX/MEM; funct3 = inst_in[14:12]
- pc_in  in  32  PC from EX/MEM
- alu_in  in  32  ALU result / effective address
- rs2_in  in  32  store data
- memread_in  in  1  load request
- memwrite_in  in  1  store request
- wbselect_in  in  2  writeback mux select, passed through
- regwrite_in  in  1  register write enable
- dst_in  in  5  destination register
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {alu_in[31:2],2'b00}
- dmem_wdata  out  32  replicated store data
- dmem_wstrb  out  4  byte write strobes
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  access complete
- stall  out  1  hold PC/IF/ID/EX/EX-MEM this cycle
- inst_out, pc_out, alu_out  out  32  MEM/WB registered copies
- mem_data_out  out  32  formatted load data
- wbselect_out  out  2  registered
- regwrite_out  out  1  registered
- dst_out  out  5  registered
- misalign_out  out  1  registered alignment/illegal-width fault

Behaviour:
- Reset (async): FSM enters IDLE. dmem_req=0, dmem_we=0, stall=0. All registered outputs are 0.
- memop = memread_in | memwrite_in. If both are set, treat as a load.
- Illegal access, checked on funct3 and alu_in[1:0]:
  - Word access with alu_in[1:0]≠0.
  - Half access with alu_in[0]=1.
  - funct3 in {011,110,111}.
- FSM states: IDLE, ACCESS.
- IDLE, no memop: MEM/WB registers load the inputs at the next edge (latency 1). mem_data_out=0, misalign_out=0.
- IDLE, memop and illegal: no request is issued, no stall. Next edge loads MEM/WB with misalign_out=1 and regwrite_out=0.
- IDLE, memop and legal:
  - stall=1 combinationally.
  - Next state is ACCESS.
  - MEM/WB loads a bubble: regwrite_out=0, misalign_out=0, other fields don't-care but zeroed.
- ACCESS:
  - dmem_req=1. addr, we, wdata, wstrb are derived from the inputs, which upstream holds stable because stall is asserted.
  - stall = ~dmem_ack.
  - While ack=0, MEM/WB loads bubbles.
  - On the edge with ack=1: MEM/WB captures the inputs plus formatted data; FSM returns to IDLE. Upstream advances on the same edge because stall=0.
  - Minimum memop latency is 2 cycles.
- Store strobes: SB gives 4'b0001<<alu_in[1:0]; SH gives 4'b0011<<alu_in[1:0]; SW gives 4'b1111. For loads dmem_wstrb=0.
- Store wdata: SB replicates {4{rs2[7:0]}}; SH replicates {2{rs2[15:0]}}; SW uses rs2.
- Load formatting, from dmem_rdata using alu_in[1:0]:
  - LB: select byte, sign-extend.
  - LBU: select byte, zero-extend.
  - LH: select halfword, sign-extend.
  - LHU: select halfword, zero-extend.
  - LW: full word.
- Store completion: mem_data_out=0.
- Reset asserted during ACCESS: immediate IDLE, dmem_req drops asynchronously, the access is abandoned, and any late ack is ignored in IDLE.
- dmem_ack while in IDLE: ignored.

Test Plan:
- LW: alu_in=0x100, rdata=0xDEADBEEF, ack 2 cycles after req. Required: stall high for 3 cycles; dmem_addr=0x100; mem_data_out=0xDEADBEEF; regwrite_out=1 one cycle after the ack edge.
- LB / LBU at alu_in=0x203, rdata=0x80123456. Required: LB gives 0xFFFFFF80; LBU gives 0x00000080; dmem_addr=0x200.
- SB at alu_in=0x301 with rs2=0x000000A5, ack same cycle as req. Required: dmem_we=1, wstrb=0010, wdata=0xA5A5A5A5, total stall 1 cycle.
- LW at alu_in=0x102. Required: dmem_req never asserts, stall=0, next cycle misalign_out=1 and regwrite_out=0.
- Non-memory op (memread=memwrite=0, alu_in=0x55) back-to-back. Required: no stall, alu_out=0x55 one cycle later, dmem_req=0.
- Assert rst during ACCESS, then pulse dmem_ack. Required: dmem_req=0 immediately, all outputs 0, FSM stays in IDLE after the ack.
